mult_sequencer: RTL

MULT_SEQUENCER -- requirements
Module: mult_sequencer

---
 rtl/mult_sequencer_pkg.sv | 14 +
 rtl/booth_recode.sv | 17 +
 rtl/mult_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mult_sequencer_pkg.sv
// Shared definitions for the radix-4 Booth multiply sequencer.
package mult_sequencer_pkg;

  localparam int MULT_WIDTH  = 32;
  localparam int MULT_GROUPS = 16;
  localparam int COUNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth recoding of one 3-bit multiplier group into add-term controls.
module booth_recode
  import mult_sequencer_pkg::*;
(
  input  logic [2:0] group,
  output logic       SHIFT,
  output logic       SUB,
  output logic       NOTHING
);

  always_comb begin
    NOTHING = (group == 3'b000) || (group == 3'b111);
    SHIFT   = (group == 3'b011) || (group == 3'b100);
    SUB     = group[2] && !NOTHING;
  end

endmodule

// File: rtl/mult_sequencer.sv
// Sequential signed multiplier: one radix-4 Booth group accumulated per cycle.
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int WIDTH  = MULT_WIDTH,
  parameter int GROUPS = MULT_GROUPS
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_cancel,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int AW = 2 * WIDTH;

  state_t             state;
  logic [COUNT_W-1:0] count;
  logic [AW-1:0]      acc;
  logic [AW-1:0]      acc_next;
  logic [AW-1:0]      a_ext;
  logic [AW-1:0]      mag;
  logic [AW-1:0]      term;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH:0]     b_pad;
  logic [WIDTH:0]     hi;
  logic [COUNT_W:0]   pos;
  logic [2:0]         grp;
  logic               shift;
  logic               sub;
  logic               nothing;
  logic               overflow;
  logic               last;

  booth_recode u_recode (
    .group  (grp),
    .SHIFT  (shift),
    .SUB    (sub),
    .NOTHING(nothing)
  );

  // pos = 2*count is both the group's bit offset in {B,0} and the term's weight.
  always_comb begin
    b_pad    = {b_reg, 1'b0};
    pos      = {count, 1'b0};
    grp      = b_pad[pos +: 3];
    a_ext    = {{WIDTH{a_reg[WIDTH-1]}}, a_reg};
    mag      = shift ? (a_ext << 1) : a_ext;
    term     = nothing ? '0 : (sub ? ('0 - mag) : mag);
    acc_next = acc + (term << pos);
    hi       = acc_next[AW-1:WIDTH-1];
    overflow = !((hi == '0) || (hi == '1));
    last     = (count == COUNT_W'(GROUPS - 1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      count          <= '0;
      acc            <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl_MULT) begin
            a_reg <= data_operandA;
            b_reg <= data_operandB;
            acc   <= '0;
            count <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (ctrl_cancel) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
          end else begin
            acc <= acc_next;
            if (last) begin
              state          <= DONE;
              data_result    <= acc_next[WIDTH-1:0];
              data_exception <= overflow;
              data_resultRDY <= 1'b1;
            end else begin
              count <= count + COUNT_W'(1);
            end
          end
        end
        DONE: begin
          data_resultRDY <= 1'b0;
          if (ctrl_MULT) begin
            a_reg <= data_operandA;
            b_reg <= data_operandB;
            acc   <= '0;
            count <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
